lsu_mem_ctrl: RTL and testbench

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

---
 rtl/lsu_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lsu_mem_ctrl: byte/half/word load-store unit, splits unaligned accesses in two
// Rev 1.0
// ---------------------------------------------------------------------------
module lsu_mem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        mem_we,
  output logic [29:0] mem_adr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [2:0] OP_LDR   = 3'd0;
  localparam logic [2:0] OP_LDRB  = 3'd1;
  localparam logic [2:0] OP_LDRSB = 3'd2;
  localparam logic [2:0] OP_LDRH  = 3'd3;
  localparam logic [2:0] OP_LDRSH = 3'd4;
  localparam logic [2:0] OP_STR   = 3'd5;
  localparam logic [2:0] OP_STRH  = 3'd7;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, asm_q, asm_nx;
  logic [29:0] adr_hold;

  logic [1:0]  off;
  logic [4:0]  sh;
  logic [3:0]  size_mask, lanes, byte_sel;
  logic [7:0]  span;
  logic        split, is_store, in_acc;
  logic [31:0] wd_rot, rd_rot, lane_bits, byte_bits;

  // Operand byte i lives in lane (off+i) mod 4: rotate left for stores,
  // rotate right for loads. span[7:4] are the lanes spilling into the next word.
  always_comb begin
    off      = addr_q[1:0];
    sh       = {off, 3'b000};
    is_store = (op_q >= OP_STR);
    in_acc   = (state == ACC1) || (state == ACC2);
    case (op_q)
      OP_LDR, OP_STR:            size_mask = 4'b1111;
      OP_LDRH, OP_LDRSH, OP_STRH: size_mask = 4'b0011;
      default:                   size_mask = 4'b0001;
    endcase
    span  = {4'b0000, size_mask} << off;
    split = |span[7:4];
    case (state)
      ACC1:    lanes = span[3:0];
      ACC2:    lanes = span[7:4];
      default: lanes = 4'b0000;
    endcase
    byte_sel = (lanes >> off) | (lanes << (3'd4 - {1'b0, off}));
    wd_rot   = (wdata_q << sh) | (wdata_q >> (6'd32 - {1'b0, sh}));
    rd_rot   = (mem_rd >> sh) | (mem_rd << (6'd32 - {1'b0, sh}));
    for (int k = 0; k < 4; k++) begin
      lane_bits[8*k +: 8] = {8{lanes[k]}};
      byte_bits[8*k +: 8] = {8{byte_sel[k]}};
    end
    asm_nx = (asm_q & ~byte_bits) | (rd_rot & byte_bits);
  end

  always_comb begin
    mem_we    = is_store && in_acc;
    mem_wmask = is_store ? lanes : 4'b0000;
    mem_wd    = is_store ? (wd_rot & lane_bits) : 32'd0;
    case (state)
      ACC1:    mem_adr = addr_q[31:2];
      ACC2:    mem_adr = addr_q[31:2] + 30'd1;
      default: mem_adr = adr_hold;
    endcase
  end

  always_comb begin
    state_nx  = state;
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
    rsp_rdata = 32'd0;
    case (state)
      IDLE:    if (req_valid) state_nx = ACC1;
      ACC1:    state_nx = split ? ACC2 : DONE;
      ACC2:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (state == DONE) begin
      case (op_q)
        OP_LDR:   rsp_rdata = asm_q;
        OP_LDRB:  rsp_rdata = {24'd0, asm_q[7:0]};
        OP_LDRSB: rsp_rdata = {{24{asm_q[7]}}, asm_q[7:0]};
        OP_LDRH:  rsp_rdata = {16'd0, asm_q[15:0]};
        OP_LDRSH: rsp_rdata = {{16{asm_q[15]}}, asm_q[15:0]};
        default:  rsp_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op_q     <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      asm_q    <= 32'd0;
      adr_hold <= 30'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        asm_q   <= 32'd0;
      end
      if (in_acc) begin
        adr_hold <= mem_adr;
        if (!is_store) asm_q <= asm_nx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl: scoreboard bench with a byte-addressed reference memory
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [29:0] mem_adr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wd, mem_rd;

  lsu_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wmask(mem_wmask),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory seen by the DUT (low 8 bits of word address) and the
  // independent byte-level reference (low 10 bits of byte address).
  logic [31:0] env_mem [256];
  logic [7:0]  ref_b   [1024];

  assign mem_rd = env_mem[mem_adr[7:0]];

  always @(posedge clk)
    if (mem_we)
      for (int k = 0; k < 4; k++)
        if (mem_wmask[k]) env_mem[mem_adr[7:0]][8*k +: 8] <= mem_wd[8*k +: 8];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t expq[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd5:       return 4;
      3'd3, 3'd4, 3'd7: return 2;
      default:          return 1;
    endcase
  endfunction

  // Access bytes addr..addr+n-1 (little-endian, 32-bit wrap) and extend.
  function automatic logic [31:0] ref_access(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] wdata);
    logic [31:0] v;
    logic [31:0] a;
    v = 32'd0;
    for (int i = 0; i < size_of(op); i++) begin
      a = addr + i;
      if (op >= 3'd5) ref_b[a[9:0]] = wdata[8*i +: 8];
      else            v[8*i +: 8]   = ref_b[a[9:0]];
    end
    if (op >= 3'd5) return 32'd0;
    if (op == 3'd2) v = {{24{v[7]}}, v[7:0]};
    if (op == 3'd4) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: actual rsp_valid=1 rdata %h required no response", rsp_rdata);
      end else begin
        mon_e = expq.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Returns #1 after the accepting edge, i.e. inside ACC1.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit abort);
    int waited;
    int lat;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: actual req_ready=0 required 1 within 20 cycles");
      req_valid = 1'b0;
      return;
    end
    if (!abort) begin
      lat     = ((int'(addr[1:0]) + size_of(op)) > 4) ? 3 : 2;
      e.rdata = ref_access(op, addr, wdata);
      e.cyc   = cyc + lat;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("idle_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] addr;
    int          waited;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    for (int w = 0; w < 256; w++) env_mem[w] = $urandom;
    env_mem[8'h40] = 32'h11223344;
    env_mem[8'h41] = 32'h55667788;
    for (int w = 0; w < 256; w++)
      for (int k = 0; k < 4; k++) ref_b[4*w + k] = env_mem[w][8*k +: 8];

    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    chk("rst_mem_adr", {2'd0, mem_adr}, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Unaligned loads spanning two words
    do_req(3'd0, 32'h102, 32'd0, 0);
    chk("ldr_acc1_we", {31'd0, mem_we}, 32'd0);
    chk("ldr_acc1_mask", {28'd0, mem_wmask}, 32'd0);
    do_req(3'd3, 32'h102, 32'd0, 0);

    do_req(3'd5, 32'h100, 32'hDEADBEEF, 0);
    chk("str_we", {31'd0, mem_we}, 32'd1);
    chk("str_adr", {2'd0, mem_adr}, 32'h40);
    chk("str_mask", {28'd0, mem_wmask}, 32'hF);
    chk("str_wd", mem_wd, 32'hDEADBEEF);
    wait_idle();
    chk("idle_adr_hold", {2'd0, mem_adr}, 32'h40);
    chk("idle_we", {31'd0, mem_we}, 32'd0);
    chk("idle_mask", {28'd0, mem_wmask}, 32'd0);

    do_req(3'd6, 32'h103, 32'h000000A5, 0);
    chk("strb_mask", {28'd0, mem_wmask}, 32'h8);
    chk("strb_wd", mem_wd, 32'hA5000000);
    do_req(3'd2, 32'h103, 32'd0, 0);
    do_req(3'd1, 32'h103, 32'd0, 0);

    do_req(3'd7, 32'h203, 32'h00008001, 0);
    chk("strh_acc1_adr", {2'd0, mem_adr}, 32'h80);
    chk("strh_acc1_mask", {28'd0, mem_wmask}, 32'h8);
    chk("strh_acc1_wd", mem_wd, 32'h01000000);
    @(posedge clk);
    #1;
    chk("strh_acc2_we", {31'd0, mem_we}, 32'd1);
    chk("strh_acc2_adr", {2'd0, mem_adr}, 32'h81);
    chk("strh_acc2_mask", {28'd0, mem_wmask}, 32'h1);
    chk("strh_acc2_wd", mem_wd, 32'h00000080);
    do_req(3'd4, 32'h203, 32'd0, 0);

    do_req(3'd0, 32'hFFFFFFFD, 32'd0, 0);
    chk("wrap_acc1_adr", {2'd0, mem_adr}, 32'h3FFFFFFF);
    @(posedge clk);
    #1;
    chk("wrap_acc2_adr", {2'd0, mem_adr}, 32'h0);

    // Reset pulsed inside ACC1 of a split store: aborted, nothing written
    do_req(3'd5, 32'h102, 32'hCAFEF00D, 1);
    chk("abort_acc1_we", {31'd0, mem_we}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_we", {31'd0, mem_we}, 32'd0);
    chk("abort_mask", {28'd0, mem_wmask}, 32'd0);
    chk("abort_adr", {2'd0, mem_adr}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_we", {31'd0, mem_we}, 32'd0);
    end

    for (int it = 0; it < 300; it++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) addr = 32'hFFFFFFFC + $urandom_range(0, 3);
      else                            addr = 32'h100 + $urandom_range(0, 32'h13F);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(op, addr, $urandom, 0);
    end

    waited = 0;
    while (expq.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("pending_rsp", expq.size(), 32'd0);
    for (int w = 0; w < 256; w++)
      chk("mem_word", env_mem[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
